// File: rtl/seq_writer_if.sv
// Write-request bus between seq_writer and the sequence memory.
// The request fields hold steady from wr_en rising until wr_ack is sampled high.
`timescale 1ns/1ps
interface seq_writer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/seq_writer.sv
// Records a sequence of switch patterns into memory, one step per debounced button press.
// The record button starts and stops a recording; the step button captures one step.
`timescale 1ns/1ps
module seq_writer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DB_LEN = 8
) (
    input  logic              i_clk_50,
    input  logic              i_reset,
    input  logic              i_tick_1k,
    input  logic              i_pb_rec,
    input  logic              i_pb_step,
    input  logic [DATA_W-1:0] i_sw_pattern,
    seq_writer_if.master      m_wr,
    output logic [ADDR_W:0]   o_seq_len,
    output logic              o_recording,
    output logic              o_full,
    output logic [DATA_W-1:0] o_leds
);

    typedef enum logic [1:0] {StIdle, StRec, StWrite, StDone} state_e;

    localparam logic [ADDR_W:0] LP_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    // Bit 0 is the record button, bit 1 the step button.
    logic [1:0][DB_LEN-1:0] r_db_sh;
    logic [1:0][DB_LEN-1:0] w_db_sh_nxt;
    logic [1:0]             r_db_lvl;
    logic [1:0]             r_db_lvl_d1;
    logic [1:0]             w_raw;
    logic [1:0]             w_press;

    state_e            r_state, w_state_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [DATA_W-1:0] r_wr_data, w_wr_data_nxt;
    logic [ADDR_W:0]   r_seq_len, w_seq_len_nxt;
    logic              r_full, w_full_nxt;
    logic              r_stop, w_stop_nxt;
    logic [ADDR_W:0]   w_len_inc;

    assign w_raw = {i_pb_step, i_pb_rec};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_db_sh_nxt[b] = {r_db_sh[b][DB_LEN-2:0], w_raw[b]};
        end
    end

    always_ff @(posedge i_clk_50 or posedge i_reset) begin
        if (i_reset) begin
            r_db_sh     <= '0;
            r_db_lvl    <= '0;
            r_db_lvl_d1 <= '0;
        end else begin
            r_db_lvl_d1 <= r_db_lvl;
            if (i_tick_1k) begin
                for (int b = 0; b < 2; b++) begin
                    r_db_sh[b] <= w_db_sh_nxt[b];
                    if (&w_db_sh_nxt[b]) begin
                        r_db_lvl[b] <= 1'b1;
                    end else if (~|w_db_sh_nxt[b]) begin
                        r_db_lvl[b] <= 1'b0;
                    end
                end
            end
        end
    end

    assign w_press   = r_db_lvl & ~r_db_lvl_d1;
    assign w_len_inc = r_seq_len + 1'b1;

    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en_nxt   = r_wr_en;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_seq_len_nxt = r_seq_len;
        w_full_nxt    = r_full;
        w_stop_nxt    = r_stop;
        unique case (r_state)
            StIdle, StDone: begin
                if (w_press[0]) begin
                    w_state_nxt   = StRec;
                    w_seq_len_nxt = '0;
                    w_full_nxt    = 1'b0;
                end
            end
            StRec: begin
                if (w_press[0]) begin
                    w_state_nxt = StDone;
                end else if (w_press[1]) begin
                    w_state_nxt   = StWrite;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_seq_len[ADDR_W-1:0];
                    w_wr_data_nxt = i_sw_pattern;
                end
            end
            StWrite: begin
                if (w_press[0]) begin
                    w_stop_nxt = 1'b1;
                end
                if (m_wr.wr_ack) begin
                    w_wr_en_nxt   = 1'b0;
                    w_seq_len_nxt = w_len_inc;
                    w_stop_nxt    = 1'b0;
                    // A rec press landing on the ack cycle still counts as a stop request.
                    if (w_len_inc == LP_MAX_LEN) begin
                        w_state_nxt = StDone;
                        w_full_nxt  = 1'b1;
                    end else if (r_stop || w_press[0]) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_state_nxt = StRec;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk_50 or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_seq_len <= '0;
            r_full    <= 1'b0;
            r_stop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_seq_len <= w_seq_len_nxt;
            r_full    <= w_full_nxt;
            r_stop    <= w_stop_nxt;
        end
    end

    assign m_wr.wr_en   = r_wr_en;
    assign m_wr.wr_addr = r_wr_addr;
    assign m_wr.wr_data = r_wr_data;
    assign o_seq_len    = r_seq_len;
    assign o_full       = r_full;
    assign o_recording  = (r_state == StRec) || (r_state == StWrite);

    always_comb begin
        o_leds = DATA_W'(r_seq_len);
        if (r_state == StRec) begin
            o_leds = i_sw_pattern;
        end else if (r_state == StWrite) begin
            o_leds = r_wr_data;
        end
    end

endmodule
